// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared widths and FSM state encoding for the Gray step checker
package gray_pkg;

  localparam int GRAY_N    = 4;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } chk_state_e;

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary conversion (XOR prefix from the MSB)
module gray2bin
  import gray_pkg::*;
#(
  parameter int N = GRAY_N
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  // Each binary bit is the XOR of the Gray bits from the MSB down to itself.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[N-1:i];
  end

endmodule

// File: rtl/gray_step_checker.sv
// rtl/gray_step_checker.sv - registers, decodes and step-checks upstream Gray codes
// Optional: GRAY_CHK_ERRCNT_EN builds the saturating step-error counter.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int N     = GRAY_N,
  parameter int CNT_W = ERR_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [N-1:0]     gray_in_i,
  output logic [N-1:0]     bin_out_o,
  output logic             bin_valid_o,
  output logic             step_err_o,
  output logic             wrap_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] err_count_o
);

  logic [N-1:0] g_q;
  logic         v1_q;
  logic [N-1:0] b;
  logic [N-1:0] prev_b_q;
  logic [N-1:0] prev_inc;
  logic         is_step;
  logic         is_rep;
  logic         is_wrap;
  logic         err_evt;

  chk_state_e   state_q;
  logic [N-1:0] bin_out_q;
  logic         bin_valid_q;
  logic         step_err_q;
  logic         wrap_q;
  logic         locked_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      g_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        g_q <= gray_in_i;
      end
    end
  end

  gray2bin #(.N(N)) u_gray2bin (
    .gray_i (g_q),
    .bin_o  (b)
  );

  // N-bit increment: 2^N-1 rolls over to 0 with no carry out.
  assign prev_inc = prev_b_q + {{(N-1){1'b0}}, 1'b1};
  assign is_step  = (b == prev_inc);
  assign is_rep   = (b == prev_b_q);
  assign is_wrap  = is_step && (prev_b_q == {N{1'b1}});
  assign err_evt  = v1_q && (state_q != ST_IDLE) && !is_step && !is_rep;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      prev_b_q    <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      bin_valid_q <= v1_q;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      if (v1_q) begin
        bin_out_q <= b;
        prev_b_q  <= b;
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_TRACK;
            locked_q <= 1'b1;
          end
          ST_TRACK: begin
            if (err_evt) begin
              step_err_q <= 1'b1;
              state_q    <= ST_FAULT;
              locked_q   <= 1'b0;
            end else begin
              wrap_q <= is_wrap;
            end
          end
          ST_FAULT: begin
            if (is_step) begin
              state_q  <= ST_TRACK;
              locked_q <= 1'b1;
              wrap_q   <= is_wrap;
            end else if (err_evt) begin
              step_err_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef GRAY_CHK_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`else
  assign err_count_o = '0;
`endif

  assign bin_out_o   = bin_out_q;
  assign bin_valid_o = bin_valid_q;
  assign step_err_o  = step_err_q;
  assign wrap_o      = wrap_q;
  assign locked_o    = locked_q;

endmodule

// File: tb/tb_gray_step_checker.sv
// tb/tb_gray_step_checker.sv - directed vector bench for gray_step_checker (N=4, CNT_W=2)
module tb_gray_step_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] gray_in;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       step_err;
  logic       wrap;
  logic       locked;
  logic [1:0] err_count;

  int n_vec  = 0;
  int n_miss = 0;

  gray_step_checker #(.N(4), .CNT_W(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .gray_in_i   (gray_in),
    .bin_out_o   (bin_out),
    .bin_valid_o (bin_valid),
    .step_err_o  (step_err),
    .wrap_o      (wrap),
    .locked_o    (locked),
    .err_count_o (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs of one sample and the outputs expected two cycles later.
  typedef struct {
    logic       vld;
    logic [3:0] gray;
    logic       bv;
    logic [3:0] bin;
    logic       err;
    logic       wrp;
    logic       lck;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [3:0] g, input logic bv,
                              input logic [3:0] b, input logic e, input logic w,
                              input logic l, input logic [1:0] c);
    vec_t r;
    r.vld = v; r.gray = g; r.bv = bv; r.bin = b;
    r.err = e; r.wrp = w; r.lck = l; r.cnt = c;
    tbl.push_back(r);
  endfunction

  function automatic logic [1:0] ec(input logic [1:0] c);
`ifdef GRAY_CHK_ERRCNT_EN
    return c;
`else
    return 2'd0;
`endif
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic check_out(input int idx, input logic bv, input logic [3:0] b, input logic e,
                           input logic w, input logic l, input logic [1:0] c);
    chk("bin_valid", idx, {7'd0, bin_valid}, {7'd0, bv});
    chk("bin_out",   idx, {4'd0, bin_out},   {4'd0, b});
    chk("step_err",  idx, {7'd0, step_err},  {7'd0, e});
    chk("wrap",      idx, {7'd0, wrap},      {7'd0, w});
    chk("locked",    idx, {7'd0, locked},    {7'd0, l});
    chk("err_count", idx, {6'd0, err_count}, {6'd0, ec(c)});
  endtask

  // Drive one cycle of inputs just after the rising edge; return at the falling edge.
  task automatic drive(input logic r, input logic v, input logic [3:0] g);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    gray_in  = g;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    gray_in  = 4'd0;

    // Basic decode, repeat across a gap, and the first stretch of the full cycle.
    add(1, 4'b0000, 1, 4'd0, 0, 0, 1, 2'd0);
    add(1, 4'b0001, 1, 4'd1, 0, 0, 1, 2'd0);
    add(1, 4'b0011, 1, 4'd2, 0, 0, 1, 2'd0);
    add(0, 4'b0000, 0, 4'd2, 0, 0, 1, 2'd0);
    add(1, 4'b0011, 1, 4'd2, 0, 0, 1, 2'd0);
    add(1, 4'b0010, 1, 4'd3, 0, 0, 1, 2'd0);
    add(1, 4'b0110, 1, 4'd4, 0, 0, 1, 2'd0);
    for (int i = 5; i < 16; i++) begin
      logic [3:0] bi;
      bi = 4'(i);
      add(1, bi ^ (bi >> 1), 1, bi, 0, 0, 1, 2'd0);
    end
    add(1, 4'b0000, 1, 4'd0, 0, 1, 1, 2'd0);
    add(1, 4'b0001, 1, 4'd1, 0, 0, 1, 2'd0);
    // Skip 1 -> 3, recover on 4, error into FAULT, repeat inside FAULT, recover.
    add(1, 4'b0010, 1, 4'd3, 1, 0, 0, 2'd1);
    add(1, 4'b0110, 1, 4'd4, 0, 0, 1, 2'd1);
    add(1, 4'b0101, 1, 4'd6, 1, 0, 0, 2'd2);
    add(1, 4'b0101, 1, 4'd6, 0, 0, 0, 2'd2);
    add(1, 4'b0100, 1, 4'd7, 0, 0, 1, 2'd2);
    // Five consecutive illegal samples: count saturates at 3.
    add(1, 4'b0000, 1, 4'd0, 1, 0, 0, 2'd3);
    add(1, 4'b0011, 1, 4'd2, 1, 0, 0, 2'd3);
    add(1, 4'b0000, 1, 4'd0, 1, 0, 0, 2'd3);
    add(1, 4'b0011, 1, 4'd2, 1, 0, 0, 2'd3);
    add(1, 4'b0000, 1, 4'd0, 1, 0, 0, 2'd3);
    add(1, 4'b0001, 1, 4'd1, 0, 0, 1, 2'd3);

    // Reset with a sample presented at the same time: the sample is dropped.
    drive(1, 1, 4'b0111);
    drive(0, 0, 4'b0000);
    check_out(-1, 0, 4'd0, 0, 0, 0, 2'd0);
    drive(0, 0, 4'b0000);
    check_out(-2, 0, 4'd0, 0, 0, 0, 2'd0);

    for (int k = 0; k < tbl.size() + 2; k++) begin
      if (k < tbl.size()) drive(0, tbl[k].vld, tbl[k].gray);
      else                drive(0, 0, 4'b0000);
      if (k >= 2) begin
        check_out(k - 2, tbl[k-2].bv, tbl[k-2].bin, tbl[k-2].err,
                  tbl[k-2].wrp, tbl[k-2].lck, tbl[k-2].cnt);
      end
    end

    // Reset mid-stream: the 0010 sample and the one presented with rst never appear.
    drive(0, 1, 4'b0011);
    drive(0, 1, 4'b0010);
    drive(1, 1, 4'b0110);
    check_out(100, 1, 4'd2, 0, 0, 1, 2'd3);
    drive(0, 0, 4'b0000);
    check_out(101, 0, 4'd0, 0, 0, 0, 2'd0);
    drive(0, 1, 4'b1010);
    check_out(102, 0, 4'd0, 0, 0, 0, 2'd0);
    drive(0, 0, 4'b0000);
    check_out(103, 0, 4'd0, 0, 0, 0, 2'd0);
    drive(0, 0, 4'b0000);
    check_out(104, 1, 4'd12, 0, 0, 1, 2'd0);
    drive(0, 0, 4'b0000);
    check_out(105, 0, 4'd12, 0, 0, 1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
